// File: rtl/mac_seq_accum.sv
// mac_seq_accum: sequencer/accumulator wrapped around the combinational fused MAC.
// Latency: one operand pair per cycle in ACC; result valid the cycle after the last operand.
// Backpressure: op_ready is a pure state decode; the result is held in DONE until res_ready.
//
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start/split_cfg/len    - sequence request, lane mode and length (latched in IDLE)
//   op_valid/op_ready      - operand handshake, op_a/op_b carry the signed pair
//   res_valid/res_ready    - result handshake, res_data carries the sign-extended sum
//   busy                   - high whenever the block is not IDLE
//   mac_split/mac_in/mac_a/mac_b/mac_out - connection to the external MAC
module mac_seq_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             split_cfg,
  input  logic [CNT_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy,
  output logic             mac_split,
  output logic [47:0]      mac_in,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [47:0]      mac_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [47:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_split;

  logic             w_start_fire;
  logic             w_op_fire;
  logic             w_last;
  logic [47:0]      w_acc_nxt;

  // r_len is never zero while in ACC (len=0 bypasses straight to DONE),
  // so the subtraction cannot wrap there.
  assign w_last = (r_cnt == (r_len - CNT_W'(1)));

  // Non-split mode only owns the low 32 bits; the upper 16 are forced to 0
  // so a stale MAC upper word can never leak into the accumulator.
  assign w_acc_nxt = r_split ? mac_out : {16'b0, mac_out[31:0]};

  // Operands go straight to the MAC; nothing is registered on that path.
  assign mac_a     = op_a;
  assign mac_b     = op_b;
  assign mac_split = r_split;
  assign mac_in    = r_split ? r_acc : {16'b0, r_acc[31:0]};
  assign res_data  = r_split ? r_acc : {{16{r_acc[31]}}, r_acc[31:0]};

  always_comb begin
    w_state_nxt  = r_state;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    w_start_fire = 1'b0;
    w_op_fire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_start_fire = 1'b1;
          w_state_nxt  = (len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        op_ready = 1'b1;
        if (op_valid) begin
          w_op_fire = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_split <= 1'b0;
    end else if (w_start_fire) begin
      r_split <= split_cfg;
      r_len   <= len;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_op_fire) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_seq_accum.sv
// Bench for mac_seq_accum with a behavioural model of the fused MAC closing the loop.
// Expected results are queued by the stimulus; a negedge monitor pops and compares.
module tb_mac_seq_accum;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             split_cfg;
  logic [CNT_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
  logic             busy;
  logic             mac_split;
  logic [47:0]      mac_in;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [47:0]      mac_out;

  always #5 clk = ~clk;

  mac_seq_accum #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .split_cfg(split_cfg),
    .len      (len),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy),
    .mac_split(mac_split),
    .mac_in   (mac_in),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_out  (mac_out)
  );

  // Behavioural fused MAC: one 32-bit lane or two independent 24-bit lanes.
  logic [31:0] p_full;
  logic [31:0] p_lo;
  logic [31:0] p_hi;
  always_comb begin
    p_full  = {{24{mac_a[7]}}, mac_a} * {{24{mac_b[7]}}, mac_b};
    p_lo    = {{24{mac_a[7]}}, mac_a} * {{28{mac_b[3]}}, mac_b[3:0]};
    p_hi    = {{24{mac_a[7]}}, mac_a} * {{28{mac_b[7]}}, mac_b[7:4]};
    mac_out = mac_in;
    if (mac_split) begin
      mac_out[23:0]  = mac_in[23:0]  + p_lo[23:0];
      mac_out[47:24] = mac_in[47:24] + p_hi[23:0];
    end else begin
      mac_out[31:0]  = mac_in[31:0] + p_full;
    end
  end

  int          checks   = 0;
  int          failures = 0;
  logic [47:0] exp_q[$];

  task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%012h expected 0x%012h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every cycle a result is presented, compare against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got 0x%012h with no result expected", res_data);
        end else if (res_ready) begin
          chk48("res_data", res_data, exp_q.pop_front());
        end else begin
          chk48("res_hold", res_data, exp_q[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic sp, input logic [CNT_W-1:0] l);
    start     = 1'b1;
    split_cfg = sp;
    len       = l;
    tick();
    start     = 1'b0;
    // Disturb the config inputs; the latched copies must be used.
    split_cfg = ~sp;
    len       = 8'hAA;
    chk1("busy_after_start", busy, 1'b1);
    chk1("op_ready_after_start", op_ready, l != '0);
    chk1("mac_split_latched", mac_split, sp);
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    int n;
    n        = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk1("op_ready_timeout", 1'b0, 1'b1);
    tick();
    op_valid = 1'b0;
    op_a     = 8'($urandom);
    op_b     = 8'($urandom);
  endtask

  task automatic finish_seq(input int hold, input logic poke_start);
    chk1("res_valid_latency", res_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      start = poke_start;
      tick();
      start = 1'b0;
      chk1("res_valid_hold", res_valid, 1'b1);
      chk1("busy_hold", busy, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk1("res_valid_after_accept", res_valid, 1'b0);
    chk1("busy_after_accept", busy, 1'b0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk1({tag, "_op_ready"}, op_ready, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk48({tag, "_res_data"}, res_data, 48'h0);
    chk48({tag, "_mac_in"}, mac_in, 48'h0);
    chk1({tag, "_mac_split"}, mac_split, 1'b0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    split_cfg = 1'b0;
    len       = '0;
    op_valid  = 1'b0;
    op_a      = 8'h00;
    op_b      = 8'h00;
    res_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_idle_zero("reset");

    // Non-split, len=3: 1 + 1 + (127 * -128) = -16254
    exp_q.push_back(48'hFFFF_FFFF_C082);
    start_seq(1'b0, 8'd3);
    send_op(8'h01, 8'h01);
    send_op(8'hFF, 8'hFF);
    send_op(8'h7F, 8'h80);
    finish_seq(0, 1'b0);

    // Split, len=2: lane0 = -3 + -2 = -5 (borrow must stay in lane 0), lane1 = 6 - 2 = 4
    exp_q.push_back(48'h0000_04FF_FFFB);
    start_seq(1'b1, 8'd2);
    send_op(8'h03, 8'h2F);
    chk48("split_mac_in_mid", mac_in, 48'h0000_06FF_FFFD);
    send_op(8'hFE, 8'h11);
    finish_seq(0, 1'b0);

    // len=0: immediate zero result, no operand accepted
    exp_q.push_back(48'h0);
    start_seq(1'b0, 8'd0);
    finish_seq(1, 1'b0);

    // Operand gaps with a stray start during ACC and DONE: 2*3 + 4*5 = 26
    exp_q.push_back(48'h0000_0000_001A);
    start_seq(1'b0, 8'd2);
    send_op(8'h02, 8'h03);
    for (int i = 0; i < 3; i++) begin
      start     = (i == 1);
      split_cfg = 1'b1;
      len       = 8'd5;
      tick();
      start = 1'b0;
      chk1("gap_op_ready", op_ready, 1'b1);
      chk1("gap_busy", busy, 1'b1);
    end
    send_op(8'h04, 8'h05);
    finish_seq(5, 1'b1);

    // Reset mid-ACC after one of three operands; nothing may be emitted
    start_seq(1'b1, 8'd3);
    send_op(8'h10, 8'h10);
    rst_n = 1'b0;
    op_a  = 8'h5A;
    op_b  = 8'hC3;
    tick();
    chk48("reset_mac_a", {40'h0, mac_a}, 48'h5A);
    chk48("reset_mac_b", {40'h0, mac_b}, 48'hC3);
    rst_n = 1'b1;
    chk_idle_zero("midreset");

    // Clean sequence after the abort: 5*6 = 30
    exp_q.push_back(48'h0000_0000_001E);
    start_seq(1'b0, 8'd1);
    send_op(8'h05, 8'h06);
    finish_seq(0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk48("scoreboard_drain", 48'(exp_q.size()), 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
